// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC target scheduler.
package plic_pkg;

  localparam int unsigned PRIO_W_DEF   = 3;
  localparam int unsigned ID_W_DEF     = 5;
  localparam int unsigned FLAT_MAX_W   = 1024;
  localparam int unsigned NO_INTERRUPT = 0;

  typedef enum logic {
    SCAN,
    CLAIM_RSP
  } sched_state_e;

  // Priority of source slot k (0-based) from a flat vector, zero-extended to 32 bits.
  function automatic logic [31:0] prio_slice(input logic [FLAT_MAX_W-1:0] flat,
                                             input int unsigned k,
                                             input int unsigned w);
    logic [FLAT_MAX_W-1:0] sh;
    logic [31:0]           r;
    sh = flat >> (k * w);
    r  = sh[31:0];
    for (int unsigned b = 0; b < 32; b++) begin
      if (b >= w) r[b] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/plic_target_scheduler_cell.sv
// plic_cell: single priority/ID comparator deciding whether a candidate beats the running best.
module plic_cell (
  input  logic        pending_i,
  input  logic        enable_i,
  input  logic [31:0] prio_i,
  input  logic [31:0] id_i,
  input  logic [31:0] best_prio_i,
  input  logic [31:0] best_id_i,
  output logic        win_o
);

  logic [31:0] eff_prio;

  always_comb begin
    eff_prio = (pending_i && enable_i) ? prio_i : '0;
    // Equal priority resolves toward the higher ID.
    win_o    = (eff_prio > best_prio_i) ||
               ((eff_prio == best_prio_i) && (id_i > best_id_i));
  end

endmodule

// File: rtl/plic_target_scheduler.sv
// Per-target PLIC scheduler: serial max-priority scan, irq generation, claim/complete handshake.
// Optional PLIC_CLAIM_COUNT_EN adds claim_count_o, a saturating count of non-zero claims.
module plic_target_scheduler
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 31,
  parameter int unsigned PRIO_W      = PRIO_W_DEF,
  parameter int unsigned ID_W        = ID_W_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_SOURCES-1:0]        pending_i,
  input  logic [NUM_SOURCES-1:0]        enable_i,
  input  logic [NUM_SOURCES*PRIO_W-1:0] priority_i,
  input  logic [PRIO_W-1:0]             threshold_i,
  output logic                          irq_o,
  input  logic                          claim_req_i,
  output logic                          claim_ack_o,
  output logic [ID_W-1:0]               claim_id_o,
  output logic [NUM_SOURCES-1:0]        claimed_o,
  input  logic                          complete_req_i,
  input  logic [ID_W-1:0]               complete_id_i,
  output logic                          complete_ack_o
`ifdef PLIC_CLAIM_COUNT_EN
  ,output logic [15:0]                  claim_count_o
`endif
);

  sched_state_e           state_q, state_d;
  logic [ID_W-1:0]        idx_q, idx_d, best_id_q, best_id_d, max_id_q, max_id_d;
  logic [ID_W-1:0]        claim_id_q, claim_id_d;
  logic [PRIO_W-1:0]      best_prio_q, best_prio_d, max_prio_q, max_prio_d;
  logic                   irq_q, irq_d, complete_ack_q, complete_ack_d;
  logic [NUM_SOURCES-1:0] in_service_q, in_service_d, claimed_q, claimed_d;
  logic [NUM_SOURCES-1:0] elig, claim_mask, complete_mask;
  logic [PRIO_W-1:0]      cand_prio, pk;
  logic                   cand_win, grant, complete_hit;
`ifdef PLIC_CLAIM_COUNT_EN
  logic [15:0]            count_q, count_d;
`endif

  always_comb begin
    elig      = '0;
    cand_prio = '0;
    grant     = 1'b0;
    pk        = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      pk      = PRIO_W'(prio_slice(FLAT_MAX_W'(priority_i), k, PRIO_W));
      elig[k] = pending_i[k] & enable_i[k] & ~in_service_q[k] & (pk != '0);
      if (idx_q == ID_W'(k + 1) && elig[k]) cand_prio = pk;
      if (max_id_q == ID_W'(k + 1) && elig[k]) grant = irq_q;
    end
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      claim_mask[k]    = claim_req_i && grant && (max_id_q == ID_W'(k + 1));
      complete_mask[k] = complete_req_i && (complete_id_i == ID_W'(k + 1));
    end
    complete_hit = |complete_mask;
  end

  plic_cell u_best_cmp (
    .pending_i   (1'b1),
    .enable_i    (1'b1),
    .prio_i      (32'(cand_prio)),
    .id_i        (32'(idx_q)),
    .best_prio_i (32'(best_prio_q)),
    .best_id_i   (32'(best_id_q)),
    .win_o       (cand_win)
  );

  always_comb begin
    state_d        = claim_req_i ? CLAIM_RSP : SCAN;
    idx_d          = idx_q + ID_W'(1);
    best_prio_d    = cand_win ? cand_prio : best_prio_q;
    best_id_d      = cand_win ? idx_q : best_id_q;
    max_prio_d     = max_prio_q;
    max_id_d       = max_id_q;
    irq_d          = (max_prio_q > threshold_i);
    in_service_d   = (in_service_q & ~complete_mask) | claim_mask;
    claimed_d      = claim_mask;
    claim_id_d     = (claim_req_i && grant) ? max_id_q : ID_W'(NO_INTERRUPT);
    complete_ack_d = complete_req_i;
    if (idx_q == ID_W'(NUM_SOURCES)) begin
      max_prio_d  = best_prio_d;
      max_id_d    = best_id_d;
      best_prio_d = '0;
      best_id_d   = '0;
      idx_d       = ID_W'(1);
    end
    // Any claim or in-range completion discards the partial pass and starts over.
    if (claim_req_i || complete_hit) begin
      idx_d       = ID_W'(1);
      best_prio_d = '0;
      best_id_d   = '0;
    end
    if (claim_req_i) begin
      max_prio_d = '0;
      max_id_d   = '0;
      irq_d      = 1'b0;
    end
`ifdef PLIC_CLAIM_COUNT_EN
    count_d = (claim_req_i && grant && count_q != '1) ? count_q + 16'd1 : count_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= SCAN;
      idx_q          <= ID_W'(1);
      best_prio_q    <= '0;
      best_id_q      <= '0;
      max_prio_q     <= '0;
      max_id_q       <= '0;
      irq_q          <= 1'b0;
      in_service_q   <= '0;
      claimed_q      <= '0;
      claim_id_q     <= '0;
      complete_ack_q <= 1'b0;
`ifdef PLIC_CLAIM_COUNT_EN
      count_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      best_prio_q    <= best_prio_d;
      best_id_q      <= best_id_d;
      max_prio_q     <= max_prio_d;
      max_id_q       <= max_id_d;
      irq_q          <= irq_d;
      in_service_q   <= in_service_d;
      claimed_q      <= claimed_d;
      claim_id_q     <= claim_id_d;
      complete_ack_q <= complete_ack_d;
`ifdef PLIC_CLAIM_COUNT_EN
      count_q        <= count_d;
`endif
    end
  end

  assign irq_o          = irq_q;
  assign claim_ack_o    = (state_q == CLAIM_RSP);
  assign claim_id_o     = claim_id_q;
  assign claimed_o      = claimed_q;
  assign complete_ack_o = complete_ack_q;
`ifdef PLIC_CLAIM_COUNT_EN
  assign claim_count_o  = count_q;
`endif

endmodule

// File: tb/tb_plic_target_scheduler.sv
// Randomized and directed bench for plic_target_scheduler against a steady-state behavioural model.
module tb_plic_target_scheduler;

  localparam int unsigned N  = 31;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 6;
  localparam int unsigned SETTLE = 2 * N + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    pending, enable, claimed;
  logic [N*PW-1:0] prio_flat;
  logic [PW-1:0]   threshold;
  logic            irq, claim_req, claim_ack, complete_req, complete_ack;
  logic [IW-1:0]   claim_id, complete_id;
`ifdef PLIC_CLAIM_COUNT_EN
  logic [15:0]     claim_count;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [N-1:0] m_insvc;
  int unsigned  m_count;

  plic_target_scheduler #(.NUM_SOURCES(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pending_i      (pending),
    .enable_i       (enable),
    .priority_i     (prio_flat),
    .threshold_i    (threshold),
    .irq_o          (irq),
    .claim_req_i    (claim_req),
    .claim_ack_o    (claim_ack),
    .claim_id_o     (claim_id),
    .claimed_o      (claimed),
    .complete_req_i (complete_req),
    .complete_id_i  (complete_id),
    .complete_ack_o (complete_ack)
`ifdef PLIC_CLAIM_COUNT_EN
    ,.claim_count_o (claim_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int unsigned i = 0; i < SETTLE; i++) tick();
  endtask

  function automatic int unsigned prio_of(input int unsigned id);
    logic [N*PW-1:0] s;
    s = prio_flat >> ((id - 1) * PW);
    return int'(s[PW-1:0]);
  endfunction

  // Highest eligible priority, then the highest ID holding that priority.
  task automatic model_best(output int unsigned bp, output int unsigned bid);
    bp  = 0;
    bid = 0;
    for (int unsigned id = 1; id <= N; id++)
      if (pending[id-1] && enable[id-1] && !m_insvc[id-1] && prio_of(id) > bp) bp = prio_of(id);
    for (int unsigned id = 1; id <= N; id++)
      if (bp != 0 && pending[id-1] && enable[id-1] && !m_insvc[id-1] && prio_of(id) == bp) bid = id;
  endtask

  task automatic set_prio(input int unsigned id, input int unsigned p);
    prio_flat[(id-1)*PW +: PW] = PW'(p);
  endtask

  task automatic do_claim(input string tag, input int unsigned exp_id);
    logic [N-1:0] exp_mask;
    exp_mask = '0;
    if (exp_id != 0) exp_mask[exp_id-1] = 1'b1;
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check({tag, "_ack"}, 32'(claim_ack), 32'd1);
    check({tag, "_id"}, 32'(claim_id), exp_id);
    check({tag, "_claimed"}, 32'(claimed), 32'(exp_mask));
    if (exp_id != 0) begin
      m_insvc[exp_id-1] = 1'b1;
      m_count++;
    end
    tick();
    check({tag, "_ack_drop"}, {claim_ack, irq, 30'(claim_id)}, 32'd0);
  endtask

  task automatic do_complete(input string tag, input int unsigned id);
    complete_req = 1'b1;
    complete_id  = IW'(id);
    tick();
    complete_req = 1'b0;
    check({tag, "_cack"}, 32'(complete_ack), 32'd1);
    if (id >= 1 && id <= N) m_insvc[id-1] = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!irq && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(irq), 32'd1);
  endtask

  initial begin
    int unsigned bp, bid, eid;
    rst_n = 1'b0; pending = '0; enable = '0; prio_flat = '0; threshold = '0;
    claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
    m_insvc = '0; m_count = 0;
    tick(); tick();
    check("rst_outs", {irq, claim_ack, complete_ack, 29'(claim_id)}, 32'd0);
    check("rst_claimed", 32'(claimed), 32'd0);
    rst_n = 1'b1;

    settle();
    check("idle_irq", 32'(irq), 32'd0);
    do_claim("idle_claim", 0);

    enable = '1; threshold = 3'd2;
    set_prio(5, 3); set_prio(9, 3);
    pending[4] = 1'b1; pending[8] = 1'b1;
    wait_irq("tie_irq", 2 * N + 1);
    threshold = 3'd3;
    tick();
    check("thr_raise", 32'(irq), 32'd0);
    threshold = 3'd2;
    tick();
    check("thr_lower", 32'(irq), 32'd1);

    // Back-to-back: second claim arrives during the first response cycle.
    claim_req = 1'b1;
    tick();
    check("b2b_first", {31'(claim_id), claim_ack}, {31'd9, 1'b1});
    check("b2b_first_claimed", 32'(claimed), 32'h100);
    m_insvc[8] = 1'b1; m_count++;
    tick();
    claim_req = 1'b0;
    check("b2b_second", {31'(claim_id), claim_ack}, {31'd0, 1'b1});
    check("b2b_second_claimed", 32'(claimed), 32'd0);

    pending[4] = 1'b0;
    settle();
    check("insvc_blocks", 32'(irq), 32'd0);
    do_complete("cmp0", 0);
    do_complete("cmp40", 40);
    settle();
    check("ignored_cmp", 32'(irq), 32'd0);
    do_complete("cmp9", 9);
    wait_irq("reassert", 2 * N + 1);
    do_claim("reclaim9", 9);

    do_complete("cmp9b", 9);
    wait_irq("relatch", 2 * N + 1);
    enable[8] = 1'b0;
    do_claim("disabled", 0);
    enable[8] = 1'b1;
    wait_irq("after_dis", 2 * N + 1);

    set_prio(5, 4); pending[4] = 1'b1;
    settle();
    claim_req = 1'b1; complete_req = 1'b1; complete_id = IW'(9);
    tick();
    claim_req = 1'b0; complete_req = 1'b0;
    check("both_claim", 32'(claim_id), 32'd5);
    check("both_cack", 32'(complete_ack), 32'd1);
    m_insvc[4] = 1'b1; m_count++;
    settle();
    check("both_irq", 32'(irq), 32'd1);
    do_claim("both_after", 9);
    do_complete("clr5", 5);
    do_complete("clr9", 9);

    for (int unsigned it = 0; it < 40; it++) begin
      pending = N'($urandom);
      enable  = N'($urandom | $urandom);
      for (int unsigned id = 1; id <= N; id++) set_prio(id, $urandom_range(0, 7));
      threshold = PW'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) do_complete("rnd_cmp", $urandom_range(0, 40));
      settle();
      model_best(bp, bid);
      check("rnd_irq", 32'(irq), 32'(bp > threshold));
      eid = (bp > threshold) ? bid : 0;
      do_claim("rnd_claim", eid);
    end

`ifdef PLIC_CLAIM_COUNT_EN
    check("count", 32'(claim_count), m_count);
`endif
    rst_n = 1'b0;
    tick();
    check("midrst", {irq, claim_ack, complete_ack, 29'(claimed)}, 32'd0);
`ifdef PLIC_CLAIM_COUNT_EN
    check("count_rst", 32'(claim_count), 32'd0);
`endif
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
